traffic_light_fsm: RTL and testbench



---
 rtl/traffic_light_fsm.sv | 123 ++++++++++++
 tb/tb_traffic_light_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: intersection controller for two signal heads (NS/EW)
// with an optional all-red pedestrian walk phase. It drives an external seconds
// delay timer. The timer is restarted on every phase entry, and its timeout
// advances the phase.
module traffic_light_fsm #(
    parameter int unsigned T_GREEN  = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ped_req,
    input  logic        timer_timeout,
    output logic [31:0] timer_delay,
    output logic        timer_reset,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic        walk,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    // Lamp patterns, {red,yellow,green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t state_q;
    state_t state_d;
    logic   entry_q;      // first cycle in the current state (timer restart cycle)
    logic   ped_pending;  // latched pedestrian request
    logic   next_dir_ew;  // direction served after a walk phase: 0 = NS, 1 = EW
    logic   advance;

    // While the timer is being restarted its timeout is stale, so it is masked
    assign advance = timer_timeout && !entry_q;
    assign state   = state_q;

    // State register plus the request/direction bookkeeping; entry flag raised on reset and on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ALL_RED_2;
            entry_q     <= 1'b1;
            ped_pending <= 1'b0;
            next_dir_ew <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);

            // A new request in the walk entry cycle beats the clear, so it is not lost
            if (ped_req)
                ped_pending <= 1'b1;
            else if (state_q == PED_WALK && entry_q)
                ped_pending <= 1'b0;

            // Remember which direction follows, so a walk inserted here resumes correctly
            if (state_q == ALL_RED_1 && state_d != ALL_RED_1)
                next_dir_ew <= 1'b1;
            else if (state_q == ALL_RED_2 && state_d != ALL_RED_2)
                next_dir_ew <= 1'b0;
        end
    end

    // Next-state decode: advance one phase on an unmasked timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:  if (advance) state_d = NS_YELLOW;
            NS_YELLOW: if (advance) state_d = ALL_RED_1;
            ALL_RED_1: if (advance) state_d = ped_pending ? PED_WALK : EW_GREEN;
            EW_GREEN:  if (advance) state_d = EW_YELLOW;
            EW_YELLOW: if (advance) state_d = ALL_RED_2;
            ALL_RED_2: if (advance) state_d = ped_pending ? PED_WALK : NS_GREEN;
            PED_WALK:  if (advance) state_d = next_dir_ew ? EW_GREEN : NS_GREEN;
            default:   state_d = ALL_RED_2;  // encoding 7 recovers to a safe all-red
        endcase
    end

    // Moore outputs: lamps, walk and timer delay decoded from the state register
    always_comb begin
        timer_reset = entry_q;
        ns_light    = LAMP_RED;
        ew_light    = LAMP_RED;
        walk        = 1'b0;
        timer_delay = T_ALLRED;
        case (state_q)
            NS_GREEN: begin
                ns_light    = LAMP_GREEN;
                timer_delay = T_GREEN;
            end
            NS_YELLOW: begin
                ns_light    = LAMP_YELLOW;
                timer_delay = T_YELLOW;
            end
            EW_GREEN: begin
                ew_light    = LAMP_GREEN;
                timer_delay = T_GREEN;
            end
            EW_YELLOW: begin
                ew_light    = LAMP_YELLOW;
                timer_delay = T_YELLOW;
            end
            PED_WALK: begin
                walk        = 1'b1;
                timer_delay = T_WALK;
            end
            default: begin
                timer_delay = T_ALLRED;  // both all-reds and the illegal code
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Testbench for traffic_light_fsm: behavioural seconds-timer (4 clk per second)
// plus a dwell-counting reference model of the phase sequence.
module tb_traffic_light_fsm;
    localparam int TG = 2, TY = 1, TA = 1, TW = 3;

    logic        clk = 0, reset = 0, ped_req = 0, force_to = 0;
    logic        timer_timeout;
    logic [31:0] timer_delay;
    logic        timer_reset;
    logic [2:0]  ns_light, ew_light, state;
    logic        walk;
    int errors = 0, checks = 0;

    localparam logic [42:0] RST_VEC = {3'd5, 3'b100, 3'b100, 1'b0, 1'b1, 32'd1};

    always #5 clk = ~clk;

    traffic_light_fsm #(.T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)) dut (
        .clk(clk), .reset(reset), .ped_req(ped_req), .timer_timeout(timer_timeout),
        .timer_delay(timer_delay), .timer_reset(timer_reset), .ns_light(ns_light),
        .ew_light(ew_light), .walk(walk), .state(state)
    );

    // Timer environment: counts clocks since its reset, times out at delay seconds
    int unsigned tcnt = 0;
    always @(posedge clk) begin
        if (timer_reset) tcnt <= 0;
        else             tcnt <= tcnt + 1;
    end
    assign timer_timeout = force_to || ((tcnt / 4) >= timer_delay);

    // Reference model: each phase lasts 4*delay+2 cycles including its entry cycle
    function automatic int dly(int s);
        case (s)
            0, 3:    return TG;
            1, 4:    return TY;
            6:       return TW;
            default: return TA;
        endcase
    endfunction

    int m_state = 5, m_age = 0;
    bit m_pend = 0, m_dir_ew = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 5; m_age <= 0; m_pend <= 0; m_dir_ew <= 0;
        end else begin
            if (m_age == 4 * dly(m_state) + 1) begin
                m_age <= 0;
                case (m_state)
                    0: m_state <= 1;
                    1: m_state <= 2;
                    2: begin m_state <= m_pend ? 6 : 3; m_dir_ew <= 1; end
                    3: m_state <= 4;
                    4: m_state <= 5;
                    5: begin m_state <= m_pend ? 6 : 0; m_dir_ew <= 0; end
                    default: m_state <= m_dir_ew ? 3 : 0;
                endcase
            end else begin
                m_age <= m_age + 1;
            end
            if (ped_req) m_pend <= 1;
            else if (m_state == 6 && m_age == 0) m_pend <= 0;
        end
    end

    function automatic logic [42:0] model_vec(int s, int age);
        logic [2:0] ns, ew;
        ns = 3'b100; ew = 3'b100;
        if (s == 0) ns = 3'b001;
        if (s == 1) ns = 3'b010;
        if (s == 3) ew = 3'b001;
        if (s == 4) ew = 3'b010;
        return {s[2:0], ns, ew, (s == 6), (age == 0), 32'(dly(s))};
    endfunction

    wire  [42:0] obs = {state, ns_light, ew_light, walk, timer_reset, timer_delay};
    logic [42:0] exp_vec;
    assign exp_vec = model_vec(m_state, m_age);

    task automatic to_drive();
        @(posedge clk); #1;
    endtask

    // Bounded wait for a DUT state; expiry counts as a failed check
    task automatic wait_state(input logic [2:0] s);
        int n;
        n = 0;
        while (state !== s && n < 200) begin to_drive(); n++; end
        if (state !== s) begin
            checks++; errors++;
            $display("FAIL wait_state: state=%0d want %0d", state, s);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1;
        repeat (3) to_drive();
        @(negedge clk);
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, RST_VEC); end
        to_drive();
        reset = 0;
        @(negedge clk);
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_entry: got %h want %h", obs, RST_VEC); end
        to_drive();
        @(negedge clk);
        checks++;
        if (state !== 3'd5 || timer_reset !== 1'b0) begin
            errors++; $display("FAIL post_entry: state=%0d trst=%b want 5/0", state, timer_reset);
        end
        to_drive();
    endtask

    task automatic test_no_ped();
        for (int i = 0; i < 100; i++) begin
            ped_req = 0;
            @(negedge clk);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL no_ped cyc %0d: got %h want %h", i, obs, exp_vec); end
            checks++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
                errors++; $display("FAIL no_ped_conflict: ns=%b ew=%b", ns_light, ew_light);
            end
            to_drive();
        end
    endtask

    task automatic test_ped_pulse(input logic [2:0] pulse_state, input logic [2:0] after_want);
        bit saw_walk;
        logic [2:0] after;
        saw_walk = 0; after = 3'd7;
        wait_state(pulse_state);
        for (int i = 0; i < 80; i++) begin
            ped_req = (i == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL ped_pulse cyc %0d: got %h want %h", i, obs, exp_vec); end
            if (state == 3'd6 && walk && timer_delay == 32'd3 && ns_light == 3'b100 && ew_light == 3'b100)
                saw_walk = 1;
            if (saw_walk && after == 3'd7 && state != 3'd6) after = state;
            to_drive();
        end
        ped_req = 0;
        checks++;
        if (!saw_walk || after !== after_want) begin
            errors++; $display("FAIL ped_pulse_seq: walk=%0b after=%0d want 1/%0d", saw_walk, after, after_want);
        end
    endtask

    task automatic test_ped_held();
        int walks;
        bit held_done;
        walks = 0; held_done = 0;
        wait_state(3'd1);
        for (int i = 0; i < 160; i++) begin
            ped_req = !held_done;
            @(negedge clk);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL ped_held cyc %0d: got %h want %h", i, obs, exp_vec); end
            if (state == 3'd6 && timer_reset) begin walks++; held_done = 1; end
            to_drive();
        end
        ped_req = 0;
        checks++;
        if (walks != 2) begin errors++; $display("FAIL ped_held_walks: got %0d want 2", walks); end
    endtask

    task automatic test_timeout_entry();
        logic [2:0] s0;
        int hits;
        hits = 0;
        for (int i = 0; i < 120 && hits < 4; i++) begin
            force_to = (m_age == 0);
            @(negedge clk);
            s0 = state;
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL to_entry cyc %0d: got %h want %h", i, obs, exp_vec); end
            to_drive();
            if (force_to) begin
                force_to = 0;
                hits++;
                @(negedge clk);
                checks++;
                if (state !== s0 || timer_reset !== 1'b0) begin
                    errors++; $display("FAIL to_entry_ignored: state=%0d trst=%b want %0d/0", state, timer_reset, s0);
                end
                to_drive();
            end
        end
        force_to = 0;
    endtask

    task automatic test_reset_mid();
        wait_state(3'd3);
        repeat (3) to_drive();
        #2 reset = 1;
        #1;
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_async: got %h want %h", obs, RST_VEC); end
        repeat (2) to_drive();
        reset = 0;
        @(negedge clk);
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_restart: got %h want %h", obs, RST_VEC); end
        to_drive();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL reset_mid cyc %0d: got %h want %h", i, obs, exp_vec); end
            to_drive();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ped_req  = ($urandom_range(0, 9) == 0);
            force_to = (m_age == 0) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec); end
            to_drive();
        end
        ped_req = 0; force_to = 0;
    endtask

    initial begin
        test_reset();
        test_no_ped();
        test_ped_pulse(3'd0, 3'd3);
        test_ped_pulse(3'd4, 3'd0);
        test_ped_held();
        test_timeout_entry();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
